// File: rtl/priority_decoder_acc.sv
// Rebuilds a data word from a stream of priority-coder bit positions, emitting word + popcount on last.
// Optional PRIO_DEC_DUP_CHECK_EN adds dup_err, flagging a frame that repeated a bit position.
module priority_decoder_acc #(
  parameter int WIDTH = 16,
  parameter int POS_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POS_W-1:0] in_pos,
  input  logic             in_empty,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [POS_W:0]   out_count
`ifdef PRIO_DEC_DUP_CHECK_EN
  ,
  output logic             dup_err
`endif
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc, acc_next, onehot;
  logic             take, take_last;

  function automatic logic [POS_W:0] popcnt(input logic [WIDTH-1:0] v);
    logic [POS_W:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + (POS_W+1)'(v[i]);
    return c;
  endfunction

  assign out_valid = (state == HOLD);
  assign in_ready  = !out_valid | out_ready;
  assign take      = in_valid & in_ready;
  assign take_last = take & in_last;
  // An empty token contributes no bit; in_pos is a don't-care then.
  assign onehot    = in_empty ? '0 : (WIDTH'(1) << in_pos);
  assign acc_next  = acc | onehot;

`ifdef PRIO_DEC_DUP_CHECK_EN
  logic dup, hit;
  assign hit = |(acc & onehot);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      out_data  <= '0;
      out_count <= '0;
`ifdef PRIO_DEC_DUP_CHECK_EN
      dup       <= 1'b0;
      dup_err   <= 1'b0;
`endif
    end else begin
      unique case (state)
        ACCUM: if (take_last) state <= HOLD;
        // A drain coinciding with a new last token reloads and stays in HOLD.
        HOLD:  if (out_ready && !take_last) state <= ACCUM;
        default: state <= ACCUM;
      endcase
      if (take) begin
        if (in_last) begin
          out_data  <= acc_next;
          out_count <= popcnt(acc_next);
          acc       <= '0;
`ifdef PRIO_DEC_DUP_CHECK_EN
          dup_err   <= dup | hit;
          dup       <= 1'b0;
`endif
        end else begin
          acc <= acc_next;
`ifdef PRIO_DEC_DUP_CHECK_EN
          if (hit) dup <= 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_priority_decoder_acc.sv
// Directed bench for priority_decoder_acc: single tokens, multi-token frames, backpressure, reset.
module tb_priority_decoder_acc;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_empty, in_last;
  logic [3:0]  in_pos;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [4:0]  out_count;
  logic        dup_err;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  priority_decoder_acc dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pos(in_pos),
    .in_empty(in_empty), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count)
`ifdef PRIO_DEC_DUP_CHECK_EN
    , .dup_err(dup_err)
`endif
  );

`ifndef PRIO_DEC_DUP_CHECK_EN
  assign dup_err = 1'b0;
`endif

  // Present one token and hold it until accepted (bounded wait).
  task automatic send(input logic [3:0] p, input logic e, input logic l);
    @(negedge clk);
    in_valid = 1'b1; in_pos = p; in_empty = e; in_last = l;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_pos = '0; in_empty = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    tests++; if (out_data !== 16'h0) begin fails++; $display("FAIL reset_data: got %h want 0000", out_data); end
    tests++; if (out_count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", out_count); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b want 1", in_ready); end
    tests++; if (dup_err !== 1'b0) begin fails++; $display("FAIL reset_dup: got %0b want 0", dup_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    send(4'd5, 1'b0, 1'b1);
    @(negedge clk);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %0b want 1", out_valid); end
    tests++; if (out_data !== 16'h0020) begin fails++; $display("FAIL single_data: got %h want 0020", out_data); end
    tests++; if (out_count !== 5'd1) begin fails++; $display("FAIL single_count: got %0d want 1", out_count); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL single_hold_ready: got %0b want 0", in_ready); end
    drain();
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_empty_and_zero();
    send(4'd9, 1'b1, 1'b1);
    @(negedge clk);
    tests++; if (out_data !== 16'h0000) begin fails++; $display("FAIL empty_data: got %h want 0000", out_data); end
    tests++; if (out_count !== 5'd0) begin fails++; $display("FAIL empty_count: got %0d want 0", out_count); end
    drain();
    send(4'd0, 1'b0, 1'b1);
    @(negedge clk);
    tests++; if (out_data !== 16'h0001) begin fails++; $display("FAIL pos0_data: got %h want 0001", out_data); end
    tests++; if (out_count !== 5'd1) begin fails++; $display("FAIL pos0_count: got %0d want 1", out_count); end
    drain();
  endtask

  task automatic test_two_tokens();
    int low;
    send(4'd1, 1'b0, 1'b0);
    send(4'd11, 1'b0, 1'b1);
    @(negedge clk);
    tests++; if (out_data !== 16'h0802) begin fails++; $display("FAIL two_data: got %h want 0802", out_data); end
    tests++; if (out_count !== 5'd2) begin fails++; $display("FAIL two_count: got %0d want 2", out_count); end
    low = -1;
    for (int i = 15; i >= 0; i--) if (out_data[i]) low = i;
    tests++; if (low !== 1) begin fails++; $display("FAIL two_prio: got %0d want 1", low); end
    drain();
  endtask

  task automatic test_backpressure();
    send(4'd15, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; in_pos = 4'd3; in_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready[%0d]: got %0b want 0", c, in_ready); end
      tests++; if (out_data !== 16'h8000 || out_valid !== 1'b1) begin
        fails++; $display("FAIL bp_hold[%0d]: got %h/%0b want 8000/1", c, out_data, out_valid); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    tests++; if (out_valid !== 1'b1 || out_data !== 16'h0008) begin
      fails++; $display("FAIL bp_reload: got %h/%0b want 0008/1", out_data, out_valid); end
    tests++; if (out_count !== 5'd1) begin fails++; $display("FAIL bp_count: got %0d want 1", out_count); end
    drain();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_pos = 4'd2; in_last = 1'b1;
    @(posedge clk); #1; in_pos = 4'd7;
    @(negedge clk);
    tests++; if (out_data !== 16'h0004 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_first: got %h/%0b/%0b want 0004/1/1", out_data, out_valid, in_ready); end
    @(posedge clk); #1; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    tests++; if (out_data !== 16'h0080 || out_valid !== 1'b1) begin
      fails++; $display("FAIL b2b_second: got %h/%0b want 0080/1", out_data, out_valid); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drained: got %0b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_dup_and_reset();
    send(4'd3, 1'b0, 1'b0);
    send(4'd3, 1'b0, 1'b0);
    send(4'd12, 1'b0, 1'b1);
    @(negedge clk);
    tests++; if (out_data !== 16'h1008) begin fails++; $display("FAIL dup_data: got %h want 1008", out_data); end
    tests++; if (out_count !== 5'd2) begin fails++; $display("FAIL dup_count: got %0d want 2", out_count); end
`ifdef PRIO_DEC_DUP_CHECK_EN
    tests++; if (dup_err !== 1'b1) begin fails++; $display("FAIL dup_flag: got %0b want 1", dup_err); end
`endif
    drain();
    send(4'd15, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b0;
    #2;
    tests++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin
      fails++; $display("FAIL mid_reset: got %h/%0b want 0000/0", out_data, out_valid); end
    #2; rst_n = 1'b1;
    send(4'd0, 1'b0, 1'b1);
    @(negedge clk);
    tests++; if (out_data !== 16'h0001) begin fails++; $display("FAIL post_reset_data: got %h want 0001", out_data); end
    tests++; if (dup_err !== 1'b0) begin fails++; $display("FAIL post_reset_dup: got %0b want 0", dup_err); end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_empty_and_zero();
    test_two_tokens();
    test_backpressure();
    test_back_to_back();
    test_dup_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
